// File: rtl/f32_pkg.sv
// f32_pkg: shared f32 word type, operator latencies and canonical constants.
package f32_pkg;
    localparam int F32_W = 32;
    typedef logic [F32_W-1:0] f32_t;
    localparam int LAT_ADD = 5;
    localparam int LAT_SUB = 5;
    localparam int LAT_MUL = 4;
    localparam int LAT_SEL = 0;
    localparam f32_t F32_ZERO = 32'h0000_0000;
    localparam f32_t F32_ONE  = 32'h3F80_0000;
endpackage

// File: rtl/f32_res_fifo.sv
// f32_res_fifo: synchronous result FIFO with the head entry always presented on dout.
module f32_res_fifo
    import f32_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  f32_t                   din,
    input  logic                   pop,
    output f32_t                   dout,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    f32_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          take;
    assign valid = count != '0;
    assign take  = pop && valid;
    assign dout  = mem[rd_ptr];
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= F32_ZERO;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (take) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(take);
        end
    no_overflow: assert property (@(posedge clk) disable iff (!rst) push |-> count < CW'(DEPTH));
endmodule

// File: rtl/f32_op_issuer.sv
// f32_op_issuer: credit-based valid/ready front end for a fixed-latency f32 operator.
// Define F32_OP_ISSUER_STATS_EN to add the issued/stalled/high-water counters.
module f32_op_issuer
    import f32_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  f32_t        in_a,
    input  f32_t        in_b,
    output logic        op_t,
    output f32_t        op_a,
    output f32_t        op_b,
    input  f32_t        op_res,
    output logic        out_valid,
    input  logic        out_ready,
    output f32_t        out_data
`ifdef F32_OP_ISSUER_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stalled,
    output logic [7:0]  stat_max_fill
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic          fire, capture;
    logic [5:0]    inflight;
    logic [CW-1:0] fifo_count;
    f32_t          last_a, last_b;
    // Every issued op owns a FIFO slot until popped, so a stalled consumer never loses a result.
    assign in_ready = rst && (int'(fifo_count) + int'(inflight) < FIFO_DEPTH);
    assign fire     = in_valid && in_ready;
    assign op_t     = fire;
    assign op_a     = fire ? in_a : last_a;
    assign op_b     = fire ? in_b : last_b;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            last_a <= F32_ZERO;
            last_b <= F32_ZERO;
        end else if (fire) begin
            last_a <= in_a;
            last_b <= in_b;
        end
    if (LATENCY == 0) begin : g_direct
        assign capture  = fire;
        assign inflight = '0;
    end else begin : g_pipe
        logic [LATENCY-1:0] pipe;
        always_ff @(posedge clk or negedge rst)
            if (!rst) pipe <= '0;
            else      pipe <= (pipe << 1) | LATENCY'(fire);
        assign capture  = pipe[LATENCY-1];
        assign inflight = 6'($countones(pipe));
    end
    f32_res_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (capture),
        .din  (op_res),
        .pop  (out_ready),
        .dout (out_data),
        .valid(out_valid),
        .count(fifo_count)
    );
`ifdef F32_OP_ISSUER_STATS_EN
    logic [7:0] fill;
    assign fill = (int'(fifo_count) > 255) ? 8'hFF : 8'(fifo_count);
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            stat_issued   <= '0;
            stat_stalled  <= '0;
            stat_max_fill <= '0;
        end else begin
            if (fire && !(&stat_issued)) stat_issued <= stat_issued + 1'b1;
            if (in_valid && !in_ready && !(&stat_stalled)) stat_stalled <= stat_stalled + 1'b1;
            if (fill > stat_max_fill) stat_max_fill <= fill;
        end
`endif
endmodule

// File: tb/tb_f32_op_issuer.sv
// tb_f32_op_issuer: three issuer configurations against a queue-based reference model.
module tb_f32_op_issuer;
    import f32_pkg::*;
    localparam int LATS   [3] = '{5, 0, 3};
    localparam int DEPTHS [3] = '{8, 2, 4};
    typedef struct { logic [31:0] d; int rdy; } ent_t;
    typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] exp; } vec_t;
    logic        clk = 1'b0;
    logic        rst;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    logic        in_valid [3];
    logic        in_ready [3];
    logic [31:0] in_a [3];
    logic [31:0] in_b [3];
    logic        op_t [3];
    logic [31:0] op_a [3];
    logic [31:0] op_b [3];
    logic [31:0] op_res [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data [3];
`ifdef F32_OP_ISSUER_STATS_EN
    logic [31:0] st_iss [3];
    logic [31:0] st_stl [3];
    logic [7:0]  st_max [3];
`endif
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %h want %h", nm, id, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : gi
        localparam int L = LATS[g];
        localparam int D = DEPTHS[g];
        ent_t        q[$];
        int          m_issued = 0;
        int          m_stalled = 0;
        int          m_maxf = 0;
        logic [31:0] m_la = '0;
        logic [31:0] m_lb = '0;
        f32_op_issuer #(.LATENCY(L), .FIFO_DEPTH(D)) dut (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid[g]),
            .in_ready     (in_ready[g]),
            .in_a         (in_a[g]),
            .in_b         (in_b[g]),
            .op_t         (op_t[g]),
            .op_a         (op_a[g]),
            .op_b         (op_b[g]),
            .op_res       (op_res[g]),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready[g]),
            .out_data     (out_data[g])
`ifdef F32_OP_ISSUER_STATS_EN
            ,
            .stat_issued  (st_iss[g]),
            .stat_stalled (st_stl[g]),
            .stat_max_fill(st_max[g])
`endif
        );
        // Operator stubs: select returns a at once, adder returns a+b L cycles later.
        if (L == 0) begin : s_sel
            assign op_res[g] = op_a[g];
        end else begin : s_add
            logic [31:0] rp [L];
            always @(posedge clk) begin
                rp[0] <= op_a[g] + op_b[g];
                for (int k = 1; k < L; k++) rp[k] <= rp[k-1];
            end
            assign op_res[g] = rp[L-1];
        end
        // Reference: an op fired in cycle c is visible from cycle c+1+L until popped;
        // the block may accept only while fewer than D ops are outstanding.
        always @(negedge clk) begin : model
            int   vis;
            logic er;
            logic fire;
            ent_t e;
            if (!rst) begin
                q.delete();
                m_issued  = 0;
                m_stalled = 0;
                m_maxf    = 0;
                m_la      = '0;
                m_lb      = '0;
                chk("rst_in_ready", g, in_ready[g], 0);
                chk("rst_out_valid", g, out_valid[g], 0);
                chk("rst_out_data", g, out_data[g], 0);
            end else begin
                vis = 0;
                foreach (q[i]) if (q[i].rdy <= cyc) vis++;
                er   = q.size() < D;
                fire = in_valid[g] && er;
                chk("in_ready", g, in_ready[g], er);
                chk("out_valid", g, out_valid[g], vis > 0);
                if (vis > 0) chk("out_data", g, out_data[g], q[0].d);
                chk("op_t", g, op_t[g], fire);
                chk("op_a", g, op_a[g], fire ? in_a[g] : m_la);
                chk("op_b", g, op_b[g], fire ? in_b[g] : m_lb);
                if (vis > m_maxf) m_maxf = vis;
                if (fire) begin
                    m_issued++;
                    m_la  = in_a[g];
                    m_lb  = in_b[g];
                    e.d   = (L == 0) ? in_a[g] : in_a[g] + in_b[g];
                    e.rdy = cyc + 1 + L;
                    q.push_back(e);
                end else if (in_valid[g]) begin
                    m_stalled++;
                end
                if (vis > 0 && out_ready[g]) void'(q.pop_front());
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          first, last, cnt, nf, dc, stale;
        logic        hit;
        logic [31:0] a0, b0;
        vec_t        tab [6];
        tab[0] = '{F32_ONE, 32'h4000_0000, F32_ONE};
        tab[1] = '{F32_ZERO, 32'h1234_5678, F32_ZERO};
        tab[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF};
        tab[3] = '{32'h7F80_0000, 32'hFF80_0000, 32'h7F80_0000};
        tab[4] = '{32'h8000_0000, F32_ONE, 32'h8000_0000};
        tab[5] = '{32'hC2F6_E979, 32'h0000_0000, 32'hC2F6_E979};
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_a[i]      = '0;
            in_b[i]      = '0;
        end
        repeat (3) step();
        rst = 1'b1;
        // Back-to-back issue with a free-running consumer
        out_ready[0] = 1'b1;
        first = -1; last = -1; cnt = 0;
        for (int j = 0; j < 25; j++) begin
            in_valid[0] = (j < 10);
            in_a[0] = $urandom;
            in_b[0] = $urandom;
            @(negedge clk);
            if (j < 10) chk("b2b_ready", 0, in_ready[0], 1);
            if (out_valid[0]) begin
                cnt++;
                if (first < 0) first = j;
                last = j;
            end
            step();
        end
        in_valid[0] = 1'b0;
        chk("b2b_first", 0, first, 6);
        chk("b2b_last", 0, last, 15);
        chk("b2b_count", 0, cnt, 10);
        // Consumer stall: credit must run out after exactly FIFO_DEPTH fires
        out_ready[0] = 1'b0;
        a0 = $urandom; b0 = $urandom;
        in_a[0] = a0; in_b[0] = b0; in_valid[0] = 1'b1;
        nf = 0; hit = 1'b0;
        for (int j = 0; j < 30 && !hit; j++) begin
            @(negedge clk);
            if (in_ready[0]) nf++;
            else hit = 1'b1;
            step();
            if (!hit) begin
                in_a[0] = $urandom;
                in_b[0] = $urandom;
            end
        end
        chk("stall_hit", 0, hit, 1);
        chk("stall_fires", 0, nf, 8);
        repeat (10) step();
        @(negedge clk);
        chk("stall_ready", 0, in_ready[0], 0);
        chk("stall_valid", 0, out_valid[0], 1);
        chk("stall_head", 0, out_data[0], a0 + b0);
        step();
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        dc = 0;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            if (out_valid[0]) dc++;
            step();
        end
        chk("drain_count", 0, dc, 8);
        in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom;
        @(negedge clk);
        chk("resume_ready", 0, in_ready[0], 1);
        step();
        in_valid[0] = 1'b0;
        repeat (8) step();
        // Zero-latency select: captured in the fire cycle, visible the next
        for (int i = 0; i < 6; i++) begin
            in_valid[1] = 1'b1;
            in_a[1] = tab[i].a;
            in_b[1] = tab[i].b;
            @(negedge clk);
            chk("sel_fire", 1, op_t[1], 1);
            chk("sel_res", 1, op_res[1], tab[i].exp);
            step();
            in_valid[1] = 1'b0;
            out_ready[1] = 1'b1;
            @(negedge clk);
            chk("sel_valid", 1, out_valid[1], 1);
            chk("sel_data", 1, out_data[1], tab[i].exp);
            step();
            out_ready[1] = 1'b0;
        end
        // Reset with three ops in flight and two buffered
        out_ready[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom;
            step();
        end
        in_valid[0] = 1'b0;
        step();
        step();
        @(negedge clk);
        chk("pre_rst_valid", 0, out_valid[0], 1);
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 0, out_valid[0], 0);
        chk("async_data", 0, out_data[0], 0);
        chk("async_ready", 0, in_ready[0], 0);
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_ready", 0, in_ready[0], 1);
        stale = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            @(negedge clk);
            if (out_valid[0]) stale++;
        end
        chk("stale_captured", 0, stale, 0);
        step();
        // 20 in_valid cycles, 4 of them stalled
        for (int j = 0; j < 12; j++) begin
            in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom;
            step();
        end
        in_valid[0] = 1'b0;
        repeat (4) step();
        out_ready[0] = 1'b1;
        repeat (20) step();
        for (int j = 0; j < 8; j++) begin
            in_valid[0] = 1'b1; in_a[0] = $urandom; in_b[0] = $urandom;
            step();
        end
        in_valid[0] = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("stats_empty", 0, out_valid[0], 0);
`ifdef F32_OP_ISSUER_STATS_EN
        chk("stat_issued", 0, st_iss[0], 16);
        chk("stat_stalled", 0, st_stl[0], 4);
        chk("stat_max_peak", 0, st_max[0], 8);
        chk("stat_max_model", 0, st_max[0], gi[0].m_maxf);
`endif
        step();
        // Depth 4, latency 3: fill, then stream through several pointer wraps
        out_ready[2] = 1'b0;
        in_valid[2] = 1'b1; in_a[2] = $urandom; in_b[2] = $urandom;
        nf = 0; hit = 1'b0;
        for (int j = 0; j < 20 && !hit; j++) begin
            @(negedge clk);
            if (in_ready[2]) nf++;
            else hit = 1'b1;
            step();
            in_a[2] = $urandom;
            in_b[2] = $urandom;
        end
        chk("wrap_fill", 2, nf, 4);
        out_ready[2] = 1'b1;
        for (int j = 0; j < 30; j++) begin
            step();
            in_a[2] = $urandom;
            in_b[2] = $urandom;
        end
        in_valid[2] = 1'b0;
        repeat (10) step();
        @(negedge clk);
        chk("wrap_empty", 2, out_valid[2], 0);
        step();
        // Random traffic on all configurations
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < 3; i++) begin
                in_valid[i]  = ($urandom_range(0, 3) != 0);
                out_ready[i] = ($urandom_range(0, 2) != 0);
                in_a[i] = $urandom;
                in_b[i] = $urandom;
            end
            step();
        end
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        repeat (20) step();
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("final_empty", i, out_valid[i], 0);
`ifdef F32_OP_ISSUER_STATS_EN
        chk("end_issued", 0, st_iss[0], gi[0].m_issued);
        chk("end_issued", 1, st_iss[1], gi[1].m_issued);
        chk("end_issued", 2, st_iss[2], gi[2].m_issued);
        chk("end_stalled", 0, st_stl[0], gi[0].m_stalled);
        chk("end_stalled", 1, st_stl[1], gi[1].m_stalled);
        chk("end_stalled", 2, st_stl[2], gi[2].m_stalled);
        chk("end_max", 0, st_max[0], gi[0].m_maxf);
        chk("end_max", 1, st_max[1], gi[1].m_maxf);
        chk("end_max", 2, st_max[2], gi[2].m_maxf);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/f32_op_issuer.md
Name: f32_op_issuer

Overview:
- Initiator-side adapter that drives one fixed-latency f32 operator (add/sub/mul/neg/select/compare).
- Those operators take a start pulse `t` and operands, and return the result exactly LATENCY cycles later with no valid or back-pressure.
- This block turns a valid/ready operand stream into `t` pulses, tracks in-flight operations, and captures each result into an output FIFO.
- It uses credit-based issue, so a result is never dropped when the consumer stalls.

Parameters:
- LATENCY, 5: cycles from the op_t issue edge to op_res valid (add/sub 5, mul 4, select 0). Legal range 0..31.
- FIFO_DEPTH, 8: result FIFO entries. Power of 2, at least 2. FIFO_DEPTH >= LATENCY+1 is required for 1 op/cycle throughput.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts the operand pair this cycle.
- in_a  in  32  operand a.
- in_b  in  32  operand b.
- op_t  out  1  issue pulse to the operator's t input.
- op_a  out  32  operand a to the operator.
- op_b  out  32  operand b to the operator.
- op_res  in  32  operator result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  32  result at FIFO head.

Behaviour:
- Reset (rst=0, asynchronous):
  - in-flight valid pipe, FIFO pointers and count cleared;
  - out_valid=0, out_data=0, in_ready=0 while asserted.
  - Operations issued before reset are discarded, even if their op_res arrives after release.
- Credit: credit = FIFO_DEPTH - fifo_count - inflight_count, where inflight_count is the number of 1s in the valid pipe.
  - in_ready = (credit > 0); it must not depend on in_valid.
- Issue (input side):
  - fire = in_valid & in_ready; op_t = fire.
  - op_a/op_b are combinational copies of in_a/in_b, held stable only while fire is high.
  - When not firing, op_a/op_b hold their last issued values (no toggling).
- Tracking: valid shift register of LATENCY bits.
  - fire enters stage 1; the bit at stage LATENCY means op_res is valid this cycle.
  - LATENCY=0: capture = fire in the same cycle.
- Capture: when capture=1, op_res is written to the FIFO tail at the clock edge.
  - Overflow cannot occur by construction; the implementation asserts fifo_count < FIFO_DEPTH at every write.
- Output: FIFO is first-word registered.
  - out_valid=1 whenever fifo_count>0; out_data = head entry.
  - Pop on out_valid & out_ready. out_data is held stable while out_valid & !out_ready.
- Simultaneous push and pop: count unchanged, both pointers advance. Push into an empty FIFO shows out_valid the next cycle.
- Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Latency: fire at edge N gives out_valid at earliest in cycle N+LATENCY+1. Results stay in strict issue order.
- Simultaneous fire and pop: credit is updated with both in the same cycle. Pop frees credit only from the next cycle; there is no combinational path from out_ready to in_ready.

Optional Feature:
- Macro F32_OP_ISSUER_STATS_EN.
- Defined: extra output ports, each zeroed at reset and saturating at all-ones:
  - stat_issued[31:0]: count of fire cycles.
  - stat_stalled[31:0]: count of in_valid & !in_ready cycles.
  - stat_max_fill[7:0]: high-water mark of fifo_count.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package f32_pkg:
  - typedef f32_t (logic [31:0]);
  - constants F32_W=32, LAT_ADD=5, LAT_SUB=5, LAT_MUL=4, LAT_SEL=0;
  - canonical constants F32_ZERO=32'h0000_0000, F32_ONE=32'h3F80_0000.
- One sub-module: f32_res_fifo (synchronous FIFO, FIFO_DEPTH x f32_t, registered head, count output). The issuer owns credit and the valid pipe.

Test Plan:
- Back-to-back issue (LATENCY=5, out_ready=1): 10 pairs, 1/cycle, stub result = a+b integer.
  - Expect: in_ready always 1; first out_valid 6 cycles after first fire; 10 results in order; no gaps.
- Consumer stall: out_ready=0, in_valid held 1.
  - Expect: exactly 8 fires, then in_ready=0 (5 in flight plus FIFO filling, total 8).
  - FIFO reaches 8 and out_data stays at the first result.
  - Release out_ready: all 8 drain in order, then issue resumes.
- LATENCY=0 with a select-style stub: fire with a=32'h3F800000.
  - Expect: captured the same cycle; out_valid the next cycle with out_data=32'h3F800000.
- Reset mid-flight: 3 ops in flight plus 2 in FIFO, then rst=0 for 2 cycles.
  - Expect: out_valid=0, out_data=0 immediately (async); after release the stale op_res is never captured; in_ready=1 one cycle after release.
- Simultaneous push/pop at full: FIFO_DEPTH=4, LATENCY=3; hold FIFO at 3 entries with a steady 1-in/1-out pattern.
  - Expect: count constant, pointers wrap past index 3 correctly, no assertion fires.
- Stats (macro defined): 20 in_valid cycles with 4 stalled.
  - Expect: stat_issued=16, stat_stalled=4, stat_max_fill equals the observed peak.
